// File: rtl/fpu_result_fifo.sv
// -----------------------------------------------------------------------------
// fpu_result_fifo
// Captures every valid fpu result into a small first-word-fall-through FIFO,
// tags each word with its IEEE-754 single-precision class at push time, and
// lets a consumer drain it through a valid/ready handshake. Words that arrive
// while the FIFO is full and not popping are dropped and raise a sticky
// Overflow flag.
//
// Optional feature (macro FPU_RESULT_STATS_EN): saturating 16-bit counters of
// accepted NaN, infinity and zero results, cleared by Clear_Stats.
//
// Ports:
//   Clock           system clock, rising edge
//   Reset           synchronous active-high reset, highest priority
//   In_Data         result word from the fpu
//   In_Data_Valid   push request
//   Out_Ready       consumer accepts the head entry
//   Clear_Overflow  clears the sticky Overflow flag
//   Data_Out        head word, all-ones when Out_Data_Valid=0
//   Class_Out       head class, 0 when Out_Data_Valid=0
//   Out_Data_Valid  FIFO holds at least one entry
//   Full / Empty    Count == DEPTH / Count == 0
//   Count           number of stored entries (ADDR_W+1 bits)
//   Overflow        sticky, set when a push is dropped
//   Clear_Stats, Nan_Count, Inf_Count, Zero_Count  (FPU_RESULT_STATS_EN only)
// -----------------------------------------------------------------------------
module fpu_result_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       In_Data,
    input  logic              In_Data_Valid,
    input  logic              Out_Ready,
    input  logic              Clear_Overflow,
    output logic [31:0]       Data_Out,
    output logic [2:0]        Class_Out,
    output logic              Out_Data_Valid,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count,
    output logic              Overflow
`ifdef FPU_RESULT_STATS_EN
    ,
    input  logic              Clear_Stats,
    output logic [15:0]       Nan_Count,
    output logic [15:0]       Inf_Count,
    output logic [15:0]       Zero_Count
`endif
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CLASS_W = 3;
    localparam int unsigned COUNT_W = ADDR_W + 1;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NORMAL    = 3'd0,
        CLS_ZERO      = 3'd1,
        CLS_SUBNORMAL = 3'd2,
        CLS_INF       = 3'd3,
        CLS_NAN       = 3'd4
    } fp_class_e;

    typedef struct packed {
        fp_class_e           cls;
        logic [DATA_W-1:0]   data;
    } entry_t;

    // Classify a single-precision word from its exponent and mantissa fields.
    function automatic fp_class_e classify(input logic [DATA_W-1:0] word);
        logic [EXP_W-1:0]  exp_f;
        logic [MANT_W-1:0] mant_f;
        fp_class_e         cls;
        exp_f  = word[30:23];
        mant_f = word[22:0];
        cls    = CLS_NORMAL;
        if (exp_f == '0) begin
            cls = (mant_f == '0) ? CLS_ZERO : CLS_SUBNORMAL;
        end else if (exp_f == '1) begin
            cls = (mant_f == '0) ? CLS_INF : CLS_NAN;
        end
        return cls;
    endfunction

    entry_t              mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0]  count_q;
    logic                overflow_q;

    logic                full_c;
    logic                empty_c;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;
    fp_class_e           in_class_c;
    entry_t              head_c;

    // Status is a pure decode of the registered count.
    assign full_c  = (count_q == COUNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

    // Handshake decode; a pop frees a slot for a push in the same cycle.
    assign pop_c      = !empty_c && Out_Ready;
    assign push_c     = In_Data_Valid && (!full_c || pop_c);
    assign drop_c     = In_Data_Valid && full_c && !pop_c;
    assign in_class_c = classify(In_Data);
    assign head_c     = mem[rd_ptr];

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge Clock) begin
        if (push_c) begin
            mem[wr_ptr] <= '{cls: in_class_c, data: In_Data};
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + COUNT_W'(1);
                2'b01:   count_q <= count_q - COUNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow_q <= 1'b0;
        end else if (drop_c) begin
            overflow_q <= 1'b1;
        end else if (Clear_Overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign Out_Data_Valid = !empty_c;
    assign Full           = full_c;
    assign Empty          = empty_c;
    assign Count          = count_q;
    assign Overflow       = overflow_q;
    assign Data_Out       = empty_c ? {DATA_W{1'b1}} : head_c.data;
    assign Class_Out      = empty_c ? CLASS_W'(0) : CLASS_W'(head_c.cls);

`ifdef FPU_RESULT_STATS_EN
    localparam int unsigned STAT_W = 16;

    logic [STAT_W-1:0] nan_cnt_q;
    logic [STAT_W-1:0] inf_cnt_q;
    logic [STAT_W-1:0] zero_cnt_q;

    // Saturating per-class counters of accepted pushes; clear beats increment.
    always_ff @(posedge Clock) begin
        if (Reset || Clear_Stats) begin
            nan_cnt_q  <= '0;
            inf_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else if (push_c) begin
            if (in_class_c == CLS_NAN && nan_cnt_q != '1) begin
                nan_cnt_q <= nan_cnt_q + STAT_W'(1);
            end
            if (in_class_c == CLS_INF && inf_cnt_q != '1) begin
                inf_cnt_q <= inf_cnt_q + STAT_W'(1);
            end
            if (in_class_c == CLS_ZERO && zero_cnt_q != '1) begin
                zero_cnt_q <= zero_cnt_q + STAT_W'(1);
            end
        end
    end

    assign Nan_Count  = nan_cnt_q;
    assign Inf_Count  = inf_cnt_q;
    assign Zero_Count = zero_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_fpu_result_fifo
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based reference model of the result FIFO.
// -----------------------------------------------------------------------------
module tb_fpu_result_fifo;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 3;

    logic               Clock;
    logic               Reset;
    logic [31:0]        In_Data;
    logic               In_Data_Valid;
    logic               Out_Ready;
    logic               Clear_Overflow;
    logic [31:0]        Data_Out;
    logic [2:0]         Class_Out;
    logic               Out_Data_Valid;
    logic               Full;
    logic               Empty;
    logic [ADDR_W:0]    Count;
    logic               Overflow;
    logic               Clear_Stats;
`ifdef FPU_RESULT_STATS_EN
    logic [15:0]        Nan_Count;
    logic [15:0]        Inf_Count;
    logic [15:0]        Zero_Count;
`endif

    fpu_result_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .In_Data        (In_Data),
        .In_Data_Valid  (In_Data_Valid),
        .Out_Ready      (Out_Ready),
        .Clear_Overflow (Clear_Overflow),
        .Data_Out       (Data_Out),
        .Class_Out      (Class_Out),
        .Out_Data_Valid (Out_Data_Valid),
        .Full           (Full),
        .Empty          (Empty),
        .Count          (Count),
        .Overflow       (Overflow)
`ifdef FPU_RESULT_STATS_EN
        ,
        .Clear_Stats    (Clear_Stats),
        .Nan_Count      (Nan_Count),
        .Inf_Count      (Inf_Count),
        .Zero_Count     (Zero_Count)
`endif
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of {class, word} plus the sticky flag and stats.
    bit [34:0] m_q[$];
    bit        m_ovf;
    int        m_nan, m_inf, m_zero;

    function automatic int ref_class(input bit [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        if (e == 0)   return (m == 0) ? 1 : 2;
        if (e == 255) return (m == 0) ? 3 : 4;
        return 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_edge(input bit v, input bit [31:0] d, input bit rdy,
                              input bit clr_ovf, input bit rst, input bit clr_st);
        bit pop;
        bit push;
        bit drop;
        int c;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_nan  = 0;
            m_inf  = 0;
            m_zero = 0;
            return;
        end
        pop  = (m_q.size() > 0) && rdy;
        push = v && ((m_q.size() < DEPTH) || pop);
        drop = v && (m_q.size() == DEPTH) && !pop;
        c    = ref_class(d);
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back({3'(c), d});
        if (drop)         m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (clr_st) begin
            m_nan = 0; m_inf = 0; m_zero = 0;
        end else if (push) begin
            if (c == 4) m_nan  = sat_inc(m_nan);
            if (c == 3) m_inf  = sat_inc(m_inf);
            if (c == 1) m_zero = sat_inc(m_zero);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        check_eq("valid",    64'(Out_Data_Valid), 64'(sz > 0));
        check_eq("data",     64'(Data_Out),  (sz > 0) ? 64'(m_q[0][31:0])  : 64'hFFFF_FFFF);
        check_eq("class",    64'(Class_Out), (sz > 0) ? 64'(m_q[0][34:32]) : 64'd0);
        check_eq("count",    64'(Count),     64'(sz));
        check_eq("full",     64'(Full),      64'(sz == DEPTH));
        check_eq("empty",    64'(Empty),     64'(sz == 0));
        check_eq("overflow", 64'(Overflow),  64'(m_ovf));
`ifdef FPU_RESULT_STATS_EN
        check_eq("nan_cnt",  64'(Nan_Count),  64'(m_nan));
        check_eq("inf_cnt",  64'(Inf_Count),  64'(m_inf));
        check_eq("zero_cnt", 64'(Zero_Count), 64'(m_zero));
`endif
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic cycle(input bit v, input bit [31:0] d, input bit rdy,
                         input bit clr_ovf, input bit rst, input bit clr_st);
        In_Data_Valid  = v;
        In_Data        = d;
        Out_Ready      = rdy;
        Clear_Overflow = clr_ovf;
        Reset          = rst;
        Clear_Stats    = clr_st;
        @(posedge Clock);
        model_edge(v, d, rdy, clr_ovf, rst, clr_st);
        #1;
        compare_all();
    endtask

    task automatic push_w(input bit [31:0] d, input bit rdy);
        cycle(1'b1, d, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, $urandom, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic bit [31:0] rand_word();
        bit [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 4))
            0: w[30:23] = 8'h00;
            1: w[30:23] = 8'hFF;
            default: ;
        endcase
        if ($urandom_range(0, 2) == 0) w[22:0] = 23'h0;
        return w;
    endfunction

    initial begin
        bit [31:0] specials[4];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'h7F80_0000;
        specials[3] = 32'hFFFF_FFFF;
        m_ovf = 1'b0; m_nan = 0; m_inf = 0; m_zero = 0;
        In_Data_Valid = 1'b0; In_Data = '0; Out_Ready = 1'b0;
        Clear_Overflow = 1'b0; Reset = 1'b1; Clear_Stats = 1'b0;

        // Reset state
        do_reset();
        check_eq("rst_data", 64'(Data_Out), 64'hFFFF_FFFF);
        check_eq("rst_empty", 64'(Empty), 64'd1);

        // Single push falls through on the next cycle
        push_w(32'h41CB_47AE, 1'b0);
        check_eq("fwft_data",  64'(Data_Out),  64'h41CB_47AE);
        check_eq("fwft_class", 64'(Class_Out), 64'd0);
        check_eq("fwft_count", 64'(Count),     64'd1);

        // Class tagging of zero, subnormal, infinity, NaN
        do_reset();
        for (int i = 0; i < 4; i++) push_w(specials[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("cls_seq_class", 64'(Class_Out), 64'(i + 1));
            check_eq("cls_seq_data",  64'(Data_Out),  64'(specials[i]));
            idle(1'b1);
        end
        check_eq("cls_drained_empty", 64'(Empty), 64'd1);
        check_eq("cls_drained_data",  64'(Data_Out), 64'hFFFF_FFFF);

        // Overflow on the ninth push, then drain and clear
        do_reset();
        for (int i = 0; i < 9; i++) push_w(32'h3F80_0000 + 32'(i), 1'b0);
        check_eq("ovf_count", 64'(Count), 64'd8);
        check_eq("ovf_full",  64'(Full), 64'd1);
        check_eq("ovf_flag",  64'(Overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("ovf_drain", 64'(Data_Out), 64'(32'h3F80_0000 + 32'(i)));
            idle(1'b1);
        end
        check_eq("ovf_drain_empty", 64'(Empty), 64'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ovf_cleared", 64'(Overflow), 64'd0);

        // Simultaneous push and pop while full, across the pointer wrap
        for (int i = 0; i < 8; i++) push_w(32'h4000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_w(32'h4100_0000 + 32'(i), 1'b1);
            check_eq("pp_count", 64'(Count), 64'd8);
            check_eq("pp_ovf",   64'(Overflow), 64'd0);
        end
        check_eq("pp_head", 64'(Data_Out), 64'h4000_0004);
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Reset while pushing discards all entries
        for (int i = 0; i < 5; i++) push_w(rand_word(), 1'b0);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("midrst_count", 64'(Count), 64'd0);
        check_eq("midrst_valid", 64'(Out_Data_Valid), 64'd0);
        check_eq("midrst_ovf",   64'(Overflow), 64'd0);

`ifdef FPU_RESULT_STATS_EN
        // Class counters ignore dropped words; Clear_Stats zeroes them
        push_w(32'h7FC0_0000, 1'b0);
        push_w(32'hFF80_0001, 1'b0);
        push_w(32'hFF80_0000, 1'b0);
        push_w(32'h0000_0000, 1'b0);
        push_w(32'h8000_0000, 1'b0);
        push_w(32'h0000_0000, 1'b0);
        push_w(32'h3F80_0000, 1'b0);
        push_w(32'h3F80_0000, 1'b0);
        push_w(32'h7FC0_0000, 1'b0);
        check_eq("st_nan",  64'(Nan_Count),  64'd2);
        check_eq("st_inf",  64'(Inf_Count),  64'd1);
        check_eq("st_zero", 64'(Zero_Count), 64'd3);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("st_clr_nan",  64'(Nan_Count),  64'd0);
        check_eq("st_clr_zero", 64'(Zero_Count), 64'd0);
        do_reset();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 99) < 60, rand_word(),
                  $urandom_range(0, 99) < 45,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_fifo.md
Name: fpu_result_fifo

Overview:
Downstream stage of the fpu. Captures every valid fpu result (Data_Out/Out_Data_Valid of the fpu wired to In_Data/In_Data_Valid here) into a small FIFO and tags each word with an IEEE-754 single-precision class. A consumer drains the FIFO through a valid/ready handshake. Provides full/empty/count status and a sticky overflow flag for results lost to backpressure.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2
ADDR_W, 3, pointer width; must equal log2(DEPTH)

Ports:
Clock  input  1  system clock; all state updates on the rising edge
Reset  input  1  synchronous, active-high reset
In_Data  input  32  result word from the fpu
In_Data_Valid  input  1  push request; In_Data is captured when high
Out_Ready  input  1  consumer accepts the head entry this cycle
Clear_Overflow  input  1  clears the sticky Overflow flag
Data_Out  output  32  head entry; 32'hFFFFFFFF when Out_Data_Valid=0
Class_Out  output  3  class of the head entry; 3'd0 when Out_Data_Valid=0
Out_Data_Valid  output  1  FIFO holds at least one entry
Full  output  1  Count == DEPTH
Empty  output  1  Count == 0
Count  output  ADDR_W+1  number of stored entries
Overflow  output  1  sticky; set when a push is dropped

Behaviour:
- Reset is synchronous and active-high; it has priority over all other inputs. After reset: wr_ptr=0, rd_ptr=0, Count=0, Empty=1, Full=0, Out_Data_Valid=0, Data_Out=32'hFFFFFFFF, Class_Out=0, Overflow=0. Storage contents are don't-care.
- Reset asserted mid-operation discards all entries on that edge. Out_Data_Valid is 0 in the following cycle.
- Class encoding is computed at the push edge from In_Data and stored alongside the word (35 bits per entry):
  - 0 normal
  - 1 zero (exp=0, mant=0, either sign)
  - 2 subnormal (exp=0, mant!=0)
  - 3 infinity (exp=255, mant=0)
  - 4 NaN (exp=255, mant!=0)
  - 5-7 unused
- Pop occurs when Out_Data_Valid && Out_Ready. Out_Ready while empty has no effect.
- Push is accepted when In_Data_Valid && (!Full || pop).
- Latency: first-word fall-through with registered storage. A word pushed at edge N appears on Data_Out/Class_Out after edge N when the FIFO was empty at N. There is no same-cycle bypass.
- Data_Out and Class_Out are driven from the head entry only when Out_Data_Valid=1. Otherwise they are forced to all-ones and 0.
- Push and pop in the same cycle: Count is unchanged and both pointers advance. This is legal when Full. It is impossible when Empty, because no pop can occur; in that case only the push happens.
- Pointers wrap modulo DEPTH. Count is tracked separately with ADDR_W+1 bits, so a full FIFO is unambiguous.
- Drop condition: In_Data_Valid && Full && !pop. The word is discarded, the pointers and Count are unchanged, and Overflow goes to 1 on that edge.
- Overflow stays 1 until Clear_Overflow or Reset. If Clear_Overflow and a drop occur in the same cycle, set wins and Overflow stays 1.
- Full, Empty, Count and Out_Data_Valid are registered state or pure decodes of registered state. They carry no combinational path from inputs.

Optional Feature:
Macro FPU_RESULT_STATS_EN.
- With the macro defined, the block adds:
  - Clear_Stats input 1
  - Nan_Count output 16
  - Inf_Count output 16
  - Zero_Count output 16
- Each counter increments on an accepted push of that class and saturates at 16'hFFFF. Dropped words are not counted.
- Counters reset to 0 on Reset or Clear_Stats. If Clear_Stats and an increment occur in the same cycle, clear wins.
- Without the macro, these ports and their logic do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset, then push 32'h41CB47AE for one cycle with Out_Ready=0. Next cycle: Out_Data_Valid=1, Data_Out=32'h41CB47AE, Class_Out=0, Count=1, Empty=0.
- Push 32'h00000000, 32'h00000001, 32'h7F800000, 32'hFFFFFFFF on consecutive cycles, then drain with Out_Ready=1. Required outputs in order: Class_Out=1,2,3,4 with the words unchanged. Afterwards Empty=1 and Data_Out=32'hFFFFFFFF.
- Push 9 words (32'h3F800000 + i, i=0..8) with Out_Ready=0. Required: Count=8, Full=1, Overflow=1, and a drain returns i=0..7 only. Pulsing Clear_Overflow then clears Overflow to 0.
- While Full, hold In_Data_Valid=1 and Out_Ready=1 for 4 cycles. Required: Count stays 8, Overflow stays 0, and the output order is preserved across the pointer wrap.
- With 5 entries stored, assert Reset for one cycle while pushing. Next cycle: Count=0, Empty=1, Out_Data_Valid=0, Overflow=0.
- FPU_RESULT_STATS_EN defined: push 2 NaN, 1 infinity and 3 zero words, plus 1 NaN while Full. Required: Nan_Count=2, Inf_Count=1, Zero_Count=3. Clear_Stats then sets all three counters to 0.
